// File: rtl/fp_wb_pkg.sv
// Shared widths and enumerations for the FP register-file write-back arbiter.
package fp_wb_pkg;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREG  = 1 << AW;
    localparam int unsigned AGE_W = 4;

    typedef enum logic [1:0] {
        REQ_ALU,
        REQ_DIV,
        REQ_LD
    } req_id_e;

    typedef enum logic {
        RUN,
        DRAIN
    } wb_state_e;

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard: one busy bit per FP register, four combinational read ports.
module fp_scoreboard
    import fp_wb_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rs3_addr,
    input  logic [AW-1:0]   rd_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rs3_busy,
    output logic            rd_busy,
    output logic [NREG-1:0] busy
);

    // Set on issue, clear on RF commit; a same-edge set overrides the clear. f0 never tracked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (set_en && set_addr == AW'(r)) begin
                    busy[r] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign rs3_busy = busy[rs3_addr];
    assign rd_busy  = busy[rd_addr];

endmodule

// File: rtl/freg_wb_arbiter.sv
// FP register-file write-port arbiter: FPU pipe priority, div/load round-robin,
// starvation throttle on issue, and RAW/WAW issue stall from the scoreboard.
module freg_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic [AW-1:0] iss_rs3,
    input  logic          iss_uses_rs3,
    input  logic          iss_writes_fp,
    output logic          iss_stall,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          div_valid,
    input  logic [AW-1:0] div_rd,
    input  logic [DW-1:0] div_data,
    output logic          div_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    localparam logic [AGE_W-1:0] STARVE_AGE = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_MAX    = '1;

    req_id_e          rr_ptr;
    req_id_e          gnt_src;
    logic             gnt_any;
    logic [AW-1:0]    gnt_rd;
    logic [DW-1:0]    gnt_data;
    logic [AGE_W-1:0] age_div, age_ld, age_div_nx, age_ld_nx;
    wb_state_e        state, state_nx;
    logic             starving;
    logic             rs1_busy, rs2_busy, rs3_busy, rd_busy;
    logic             sb_set;
    logic [NREG-1:0]  busy_vec;

    fp_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (sb_set),
        .set_addr (iss_rd),
        .clr_en   (rf_we),
        .clr_addr (rf_wa),
        .rs1_addr (iss_rs1),
        .rs2_addr (iss_rs2),
        .rs3_addr (iss_rs3),
        .rd_addr  (iss_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rs3_busy (rs3_busy),
        .rd_busy  (rd_busy),
        .busy     (busy_vec)
    );

    // Grant: FPU pipe unconditionally, else div/ld with rr_ptr breaking the tie.
    always_comb begin
        div_ready = 1'b0;
        ld_ready  = 1'b0;
        gnt_src   = REQ_ALU;
        gnt_any   = alu_valid;
        if (!alu_valid) begin
            if (div_valid && (!ld_valid || rr_ptr == REQ_DIV)) begin
                div_ready = 1'b1;
                gnt_src   = REQ_DIV;
                gnt_any   = 1'b1;
            end else if (ld_valid) begin
                ld_ready  = 1'b1;
                gnt_src   = REQ_LD;
                gnt_any   = 1'b1;
            end
        end
    end

    // Write-data mux for the winning requester.
    always_comb begin
        gnt_rd   = alu_rd;
        gnt_data = alu_data;
        case (gnt_src)
            REQ_DIV: begin gnt_rd = div_rd; gnt_data = div_data; end
            REQ_LD:  begin gnt_rd = ld_rd;  gnt_data = ld_data;  end
            default: ;
        endcase
    end

    // Wait ages: count while requesting without grant, saturate, clear otherwise.
    always_comb begin
        age_div_nx = '0;
        age_ld_nx  = '0;
        if (div_valid && !div_ready) begin
            age_div_nx = (age_div == AGE_MAX) ? age_div : age_div + 1'b1;
        end
        if (ld_valid && !ld_ready) begin
            age_ld_nx = (age_ld == AGE_MAX) ? age_ld : age_ld + 1'b1;
        end
    end

    // Throttle FSM: judged on next-cycle ages, so DRAIN starts at the edge a requester
    // hits the limit and ends once every starving requester has been granted.
    always_comb begin
        state_nx = state;
        starving = (age_div_nx >= STARVE_AGE) || (age_ld_nx >= STARVE_AGE);
        case (state)
            RUN:     if (starving)  state_nx = DRAIN;
            DRAIN:   if (!starving) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Issue hazard check and scoreboard set request.
    always_comb begin
        iss_stall = iss_valid & (rs1_busy | rs2_busy | (iss_uses_rs3 & rs3_busy)
                               | (iss_writes_fp & rd_busy) | (state == DRAIN));
        sb_set    = iss_valid & ~iss_stall & iss_writes_fp & (iss_rd != '0);
    end

    // Arbiter state: round-robin pointer, ages and throttle state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr  <= REQ_DIV;
            age_div <= '0;
            age_ld  <= '0;
            state   <= RUN;
        end else begin
            if (div_ready)     rr_ptr <= REQ_LD;
            else if (ld_ready) rr_ptr <= REQ_DIV;
            age_div <= age_div_nx;
            age_ld  <= age_ld_nx;
            state   <= state_nx;
        end
    end

    // Registered RF write port, one cycle behind the grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= gnt_any;
            if (gnt_any) begin
                rf_wa <= gnt_rd;
                rf_wd <= gnt_data;
            end
        end
    end

    a_div_hold: assert property (@(posedge clock) disable iff (reset)
        (div_valid && !div_ready) |=> (div_valid && $stable(div_rd) && $stable(div_data)));

    a_ld_hold: assert property (@(posedge clock) disable iff (reset)
        (ld_valid && !ld_ready) |=> (ld_valid && $stable(ld_rd) && $stable(ld_data)));

    a_alu_busy: assert property (@(posedge clock) disable iff (reset)
        (alu_valid && alu_rd != '0) |-> busy_vec[alu_rd]);

endmodule
